dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the target side of the pipeline's MEM-stage load/store port. It accepts one request at a time from the CPU's EX/MEM stage and completes it after a fixed, parameterised latency. It returns read data and a one-cycle acknowledge, and drives a stall that freezes the pipeline while the access is outstanding. It replaces the zero-wait combinational data memory so the core can be exercised against realistic memory latency.

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_array.sv | 19 +
 rtl/dmem_responder.sv | 66 ++++++
 tb/tb_dmem_responder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, word width and width helpers for dmem_responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam int DMEM_WORD_W = 32;
  function automatic int idx_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int cnt_w(input int latency);
    return latency > 1 ? $clog2(latency) : 1;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTHx32 storage, one sync write port, one registered read port (only the read register resets)
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we,
  input  logic                     re,
  input  logic                     clr,
  input  logic [idx_w(DEPTH)-1:0]  idx,
  input  logic [DMEM_WORD_W-1:0]   wdata,
  output logic [DMEM_WORD_W-1:0]   rdata
);
  logic [DMEM_WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) if (we) mem[idx] <= wdata;
  always_ff @(posedge clk_i) rdata <= (rst_i || clr) ? '0 : re ? mem[idx] : rdata;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory target with stall/ack; DMEM_ERR_CHECK_EN enables misalign/range errors
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o
);
  localparam int IW = idx_w(DEPTH);
  localparam int CW = cnt_w(LATENCY);
  dmem_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic we_q, bad, fire, err_q;
  logic [31:0] addr_q, wdata_q;
  assign fire = state == WAIT && cnt == '0 && !rst_i;
`ifdef DMEM_ERR_CHECK_EN
  assign bad = addr_q[1:0] != 2'b00 || addr_q[31:2] >= 30'(DEPTH);
`else
  assign bad = 1'b0 & ^{addr_q[1:0], addr_q[31:IW+2]};
`endif
  always_comb begin
    state_n = state == IDLE ? (req_i ? WAIT : IDLE) : state == WAIT ? (cnt == '0 ? RESP : WAIT) : IDLE;
    cnt_n = (state == IDLE && req_i) ? CW'(LATENCY - 1) : (state == WAIT && cnt != '0) ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err_q <= fire & bad;
    end
  end
  always_ff @(posedge clk_i) begin
    if (state == IDLE && req_i) begin
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end
  assign ack_o   = state == RESP;
  assign stall_o = req_i & ~ack_o;
  assign err_o   = err_q;
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (fire & we_q & ~bad),
    .re    (fire & ~we_q & ~bad),
    .clr   (fire & ~we_q & bad),
    .idx   (addr_q[2 +: IW]),
    .wdata (wdata_q),
    .rdata (rdata_o)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven scoreboard bench for dmem_responder (LATENCY=4 and LATENCY=1 instances)
module tb_dmem_responder;
  import dmem_pkg::*;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic err;} vec_t;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  logic clk = 0, rst = 1, req = 0, we = 0, ack, stall, err;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic req1 = 0, we1 = 0, ack1, stall1, err1;
  logic [31:0] addr1 = 0, wdata1 = 0, rdata1;
  int tests = 0, fails = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[7];
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(32), .LATENCY(4)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack), .rdata_o(rdata), .stall_o(stall), .err_o(err)
  );
  dmem_responder #(.DEPTH(32), .LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
    .ack_o(ack1), .rdata_o(rdata1), .stall_o(stall1), .err_o(err1)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ack) begin
      if (sb.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("ack_rdata", rdata, mon_e.rdata);
        chk("ack_err", {31'd0, err}, {31'd0, mon_e.err});
      end
    end
  end
  task automatic wait_ack(output int n);
    n = 0;
    while (!ack && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic access(input vec_t v, input string name);
    int n = 0;
    @(posedge clk); #1;
    req = 1; we = v.we; addr = v.addr; wdata = v.wdata;
    sb.push_back('{v.rdata, v.err});
    for (int i = 0; i < 20 && !ack; i++) begin
      @(negedge clk);
      if (stall) n++;
    end
    chk({name, "_ack"}, {31'd0, ack}, 32'd1);
    chk({name, "_stall_cycles"}, n, 32'd5);
    @(posedge clk); #1;
    req = 0;
    @(negedge clk);
    chk({name, "_ack_one_cycle"}, {31'd0, ack}, 32'd0);
  endtask
  initial begin
    int n, acks;
    for (int i = 0; i < 32; i++) begin
      u0.u_array.mem[i] = 32'h1000_0000 + i;
      u1.u_array.mem[i] = 32'h1000_0000 + i;
    end
    u0.u_array.mem[3] = 32'hDEADBEEF;
    u1.u_array.mem[3] = 32'hDEADBEEF;
    tbl[0] = '{1'b0, 32'h0C, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b1, 32'h10, 32'h12345678, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0};
    tbl[3] = '{1'b0, 32'h04, 32'h0, 32'h10000001, 1'b0};
    tbl[4] = '{1'b1, 32'h7C, 32'hCAFEF00D, 32'h10000001, 1'b0};
    tbl[5] = '{1'b0, 32'h7C, 32'h0, 32'hCAFEF00D, 1'b0};
    tbl[6] = '{1'b0, 32'h08, 32'h0, 32'h10000002, 1'b0};
    req = 1;
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall_follows_req", {31'd0, stall}, 32'd1);
    chk("rst_state", u0.state, IDLE);
    @(posedge clk); #1;
    rst = 0; req = 0;
    for (int i = 0; i < 7; i++) access(tbl[i], $sformatf("vec%0d", i));
    @(posedge clk); #1;
    req = 1; we = 1; addr = 32'h14; wdata = 32'hAAAA0005;
    sb.push_back('{32'h10000002, 1'b0});
    wait_ack(n);
    chk("b2b_first_ack", {31'd0, ack}, 32'd1);
    @(posedge clk); #1;
    we = 0;
    sb.push_back('{32'hAAAA0005, 1'b0});
    wait_ack(n);
    chk("b2b_ack_spacing", n, 32'd6);
    @(posedge clk); #1;
    req = 0;
    @(posedge clk); #1;
    req = 1; we = 0; addr = 32'h04;
    sb.push_back('{32'h10000001, 1'b0});
    @(posedge clk); #1;
    req = 0;
    wait_ack(n);
    chk("req_drop_ack_cycle", n, 32'd5);
    @(posedge clk); #1;
    req = 1; we = 1; addr = 32'h20; wdata = 32'h77777777;
    @(posedge clk); #1;
    req = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_state", u0.state, IDLE);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("midrst_no_ack", acks, 32'd0);
    access('{1'b0, 32'h20, 32'h0, 32'h10000008, 1'b0}, "midrst_array_unchanged");
`ifdef DMEM_ERR_CHECK_EN
    access('{1'b1, 32'h06, 32'h55555555, 32'h10000008, 1'b1}, "err_store");
    access('{1'b0, 32'h80, 32'h0, 32'h00000000, 1'b1}, "err_load");
    access('{1'b0, 32'h04, 32'h0, 32'h10000001, 1'b0}, "err_store_suppressed");
`else
    access('{1'b1, 32'h06, 32'h55555555, 32'h10000008, 1'b0}, "wrap_store");
    access('{1'b0, 32'h80, 32'h0, 32'h10000000, 1'b0}, "wrap_load");
    access('{1'b0, 32'h04, 32'h0, 32'h55555555, 1'b0}, "wrap_store_hit");
`endif
    @(posedge clk); #1;
    req1 = 1; we1 = 0; addr1 = 32'h0C;
    n = 0;
    for (int i = 0; i < 20 && !ack1; i++) begin
      @(negedge clk);
      if (stall1) n++;
    end
    chk("lat1_ack", {31'd0, ack1}, 32'd1);
    chk("lat1_stall_cycles", n, 32'd2);
    chk("lat1_rdata", rdata1, 32'hDEADBEEF);
    chk("lat1_err", {31'd0, err1}, 32'd0);
    @(posedge clk); #1;
    req1 = 0;
    @(negedge clk);
    chk("lat1_ack_one_cycle", {31'd0, ack1}, 32'd0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
